// File: rtl/cache_lookup_ctrl_pkg.sv
// Shared widths, FSM states and request payload for the 8-way, 128-set cache lookup controller.
package cache_lookup_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SET_W  = 7;
    localparam int unsigned OFF_W  = 6;
    localparam int unsigned WAYS   = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned TAG_W  = ADDR_W - SET_W - OFF_W;
    localparam int unsigned SETS   = 1 << SET_W;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL_REQ,
        ST_REFILL_WAIT,
        ST_FILL,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
    } req_t;

    // Index of the lowest set bit; an all-zero vector maps to way 0.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [WAYS-1:0] vec);
        lowest_idx = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (vec[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/cache_lookup_ctrl_tag_way_cmp.sv
// Eight valid-gated tag comparators producing the hit one-hot, hit flag and hit index.
module tag_way_cmp
    import cache_lookup_ctrl_pkg::*;
(
    input  logic [TAG_W-1:0]      i_tag,
    input  logic [WAYS*TAG_W-1:0] i_way_tags,
    input  logic [WAYS-1:0]       i_way_valid,
    output logic [WAYS-1:0]       o_hit_oh_c,
    output logic                  o_hit_c,
    output logic [IDX_W-1:0]      o_hit_idx_c
);

    always_comb begin
        o_hit_oh_c = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            o_hit_oh_c[w] = i_way_valid[w] && (i_way_tags[w*TAG_W +: TAG_W] == i_tag);
        end
    end

    assign o_hit_c     = |o_hit_oh_c;
    assign o_hit_idx_c = lowest_idx(o_hit_oh_c);

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Cache lookup controller: tag/valid store, hit/miss resolution, refill handshake, LRU promote strobes.
// Optional CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_lookup_ctrl
    import cache_lookup_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [IDX_W-1:0]  resp_way,
    output logic [SET_W-1:0]  lru_addr_7,
    output logic [WAYS-1:0]   lru_hit_way_8,
    output logic              lru_hit_sig,
    output logic              lru_update_en,
    input  logic [WAYS-1:0]   lru_flag_8,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`endif
);

    state_t                r_state, w_state_nxt;
    req_t                  r_req;
    logic [IDX_W-1:0]      r_way;
    logic                  r_resp_hit;
    logic [SETS-1:0][WAYS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag_mem [SETS][WAYS];

    logic [WAYS*TAG_W-1:0] w_row_tags;
    logic [WAYS-1:0]       w_hit_oh;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_hit_idx;
    logic [WAYS-1:0]       w_invalid;
    logic [IDX_W-1:0]      w_victim_idx;
    logic                  w_accept;
    logic                  w_upd;
    logic [WAYS-1:0]       w_upd_oh;
    logic                  w_unused_off;

    assign w_unused_off = ^req_addr[OFF_W-1:0];

    always_comb begin
        w_row_tags = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_row_tags[w*TAG_W +: TAG_W] = r_tag_mem[r_req.set][w];
        end
    end

    tag_way_cmp u_cmp (
        .i_tag       (r_req.tag),
        .i_way_tags  (w_row_tags),
        .i_way_valid (r_valid[r_req.set]),
        .o_hit_oh_c  (w_hit_oh),
        .o_hit_c     (w_hit),
        .o_hit_idx_c (w_hit_idx)
    );

    // Invalid ways are filled first; only a full set consults the LRU victim.
    assign w_invalid    = ~r_valid[r_req.set];
    assign w_victim_idx = (|w_invalid) ? lowest_idx(w_invalid) : lowest_idx(lru_flag_8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_upd       = 1'b0;
        w_upd_oh    = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_upd       = 1'b1;
                    w_upd_oh    = w_hit_oh;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_REFILL_REQ;
                end
            end
            ST_REFILL_REQ:  if (mem_req_ready)  w_state_nxt = ST_REFILL_WAIT;
            ST_REFILL_WAIT: if (mem_resp_valid) w_state_nxt = ST_FILL;
            ST_FILL: begin
                w_upd       = 1'b1;
                w_upd_oh    = WAYS'(1) << r_way;
                w_state_nxt = ST_RESP;
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= '0;
            r_way      <= '0;
            r_resp_hit <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req.tag <= req_addr[ADDR_W-1 -: TAG_W];
                r_req.set <= req_addr[OFF_W +: SET_W];
            end
            if (r_state == ST_LOOKUP) begin
                r_resp_hit <= w_hit;
                r_way      <= w_hit ? w_hit_idx : w_victim_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_valid <= '0;
        else if (r_state == ST_FILL) r_valid[r_req.set][r_way] <= 1'b1;
    end

    // Tags carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (r_state == ST_FILL) r_tag_mem[r_req.set][r_way] <= r_req.tag;
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_hit      = r_resp_hit;
    assign resp_way      = r_way;
    assign lru_addr_7    = r_req.set;
    assign lru_update_en = w_upd;
    assign lru_hit_sig   = w_upd;
    assign lru_hit_way_8 = w_upd_oh;
    assign mem_req_valid = (r_state == ST_REFILL_REQ);
    assign mem_req_addr  = {r_req.tag, r_req.set, OFF_W'(0)};

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (resp_valid) begin
            if (resp_hit && (r_hit_cnt != '1))        r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
            else if (!resp_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
